// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-rate generator: divisor type and default
// divisors for common baud rates at a 50 MHz system clock with x16 oversampling.
package uart_pkg;

    localparam int unsigned DIV_W_DEF  = 16;
    localparam int unsigned FRAC_W_DEF = 4;
    localparam int unsigned OVS_DEF    = 16;
    localparam int unsigned CLK_HZ_DEF = 50_000_000;

    // Integer + fractional divisor; the fraction is div_frac / 2^FRAC_W_DEF.
    typedef struct packed {
        logic [DIV_W_DEF-1:0]  div_int;
        logic [FRAC_W_DEF-1:0] div_frac;
    } baud_div_t;

    // 50 MHz / (baud * 16), fraction rounded to the nearest 1/16.
    localparam baud_div_t BAUD_2400  = '{div_int: 16'd1302, div_frac: 4'd1};
    localparam baud_div_t BAUD_4800  = '{div_int: 16'd651,  div_frac: 4'd1};
    localparam baud_div_t BAUD_9600  = '{div_int: 16'd325,  div_frac: 4'd8};
    localparam baud_div_t BAUD_19200 = '{div_int: 16'd162,  div_frac: 4'd12};

    // Divisor for an arbitrary clock/baud/oversampling triple, rounded to the
    // nearest fractional step. Intended for elaboration-time constants.
    function automatic baud_div_t calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud,
                                                input int unsigned ovs);
        logic [63:0] den;
        logic [63:0] scaled;
        baud_div_t   div;
        den          = 64'(baud) * 64'(ovs);
        scaled       = ((64'(clk_hz) << FRAC_W_DEF) + (den >> 1)) / den;
        div.div_int  = DIV_W_DEF'(scaled >> FRAC_W_DEF);
        div.div_frac = FRAC_W_DEF'(scaled);
        return div;
    endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// Fractional prescaler: holds the active divisor, counts system clocks and flags
// the terminal cycle of each oversampling period. The fractional accumulator
// stretches one period by a single cycle whenever it overflows.
module uart_baud_prescaler
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W    = DIV_W_DEF,
    parameter int unsigned FRAC_W   = FRAC_W_DEF,
    parameter int unsigned RST_INT  = 32'(BAUD_9600.div_int),
    parameter int unsigned RST_FRAC = 32'(BAUD_9600.div_frac)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              apply,
    input  logic [DIV_W-1:0]  apply_int,
    input  logic [FRAC_W-1:0] apply_frac,
    output logic              terminal,
    output logic              div_zero
);

    localparam logic [DIV_W-1:0]  ACT_INT_RST  = DIV_W'(RST_INT);
    localparam logic [FRAC_W-1:0] ACT_FRAC_RST = FRAC_W'(RST_FRAC);

    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic              carry_q, carry_d;
    logic [DIV_W:0]    term_cnt;
    logic [FRAC_W:0]   frac_sum;

    assign div_zero = (act_int_q == '0);

    // Last count of the current period; one cycle later when the previous
    // terminal overflowed the fractional accumulator.
    assign term_cnt = {1'b0, act_int_q} - (DIV_W + 1)'(1) + (DIV_W + 1)'(carry_q);
    assign terminal = enable && !div_zero && ({1'b0, cnt_q} == term_cnt);
    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, act_frac_q};

    // Next-state for the period counter and fractional accumulator.
    always_comb begin
        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;
        if (!enable || div_zero) begin
            // Stopped or unusable divisor: hold everything at the start of a period.
            cnt_d      = '0;
            frac_acc_d = '0;
            carry_d    = 1'b0;
        end else if (terminal) begin
            cnt_d                 = '0;
            {carry_d, frac_acc_d} = frac_sum;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Next-state for the active divisor; only a transfer from pending changes it.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        if (apply) begin
            act_int_d  = apply_int;
            act_frac_d = apply_frac;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_int_q  <= ACT_INT_RST;
            act_frac_q <= ACT_FRAC_RST;
            cnt_q      <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            cnt_q      <= cnt_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable fractional baud-rate generator. Produces a single-cycle
// oversampling tick (rx_tick) and a bit-rate tick (tx_tick, every OVS-th
// rx_tick) used as clock enables by the Rx/Tx engines. A new divisor is staged
// in a pending register and swapped in on a period boundary so no period is
// ever truncated while running.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W    = DIV_W_DEF,
    parameter int unsigned FRAC_W   = FRAC_W_DEF,
    parameter int unsigned OVS      = OVS_DEF,
    parameter int unsigned RST_INT  = 32'(BAUD_9600.div_int),
    parameter int unsigned RST_FRAC = 32'(BAUD_9600.div_frac)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              load_done,
    output logic              cfg_err
);

    localparam int unsigned      OVS_W       = $clog2(OVS);
    localparam logic [OVS_W-1:0] OVS_LAST    = OVS_W'(OVS - 1);
    localparam logic             CFG_ERR_RST = (RST_INT == 0);

    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_valid_q, pend_valid_d;
    logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
    logic              rx_tick_q, rx_tick_d;
    logic              tx_tick_q, tx_tick_d;
    logic              load_done_q, load_done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              terminal;
    logic              div_zero;
    logic              apply;

    // While running, the swap waits for a period boundary; when stopped or when
    // the active divisor is unusable there is no period to protect.
    assign apply = pend_valid_q && (!enable || div_zero || terminal);

    uart_baud_prescaler #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .RST_INT  (RST_INT),
        .RST_FRAC (RST_FRAC)
    ) u_prescaler (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .apply      (apply),
        .apply_int  (pend_int_q),
        .apply_frac (pend_frac_q),
        .terminal   (terminal),
        .div_zero   (div_zero)
    );

    // Pending divisor: a new load always wins, even over a same-cycle transfer,
    // so a load landing on a terminal is kept for the following boundary.
    always_comb begin
        pend_int_d   = pend_int_q;
        pend_frac_d  = pend_frac_q;
        pend_valid_d = pend_valid_q;
        if (div_load) begin
            pend_int_d   = div_int;
            pend_frac_d  = div_frac;
            pend_valid_d = 1'b1;
        end else if (apply) begin
            pend_valid_d = 1'b0;
        end
    end

    // Oversampling phase: advances once per rx period, wraps after OVS periods.
    always_comb begin
        ovs_cnt_d = ovs_cnt_q;
        if (!enable) begin
            ovs_cnt_d = '0;
        end else if (terminal) begin
            ovs_cnt_d = (ovs_cnt_q == OVS_LAST) ? '0 : ovs_cnt_q + OVS_W'(1);
        end
    end

    // Output next-state; cfg_err tracks the divisor that becomes active.
    always_comb begin
        rx_tick_d   = terminal;
        tx_tick_d   = terminal && (ovs_cnt_q == OVS_LAST);
        load_done_d = apply;
        cfg_err_d   = cfg_err_q;
        if (apply) begin
            cfg_err_d = (pend_int_q == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_int_q   <= '0;
            pend_frac_q  <= '0;
            pend_valid_q <= 1'b0;
            ovs_cnt_q    <= '0;
            rx_tick_q    <= 1'b0;
            tx_tick_q    <= 1'b0;
            load_done_q  <= 1'b0;
            cfg_err_q    <= CFG_ERR_RST;
        end else begin
            pend_int_q   <= pend_int_d;
            pend_frac_q  <= pend_frac_d;
            pend_valid_q <= pend_valid_d;
            ovs_cnt_q    <= ovs_cnt_d;
            rx_tick_q    <= rx_tick_d;
            tx_tick_q    <= tx_tick_d;
            load_done_q  <= load_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign rx_tick   = rx_tick_q;
    assign tx_tick   = tx_tick_q;
    assign load_done = load_done_q;
    assign cfg_err   = cfg_err_q;

    // A bit-rate tick is always one of the oversampling ticks.
    tx_on_rx: assert property (@(posedge clock) disable iff (!reset_n) tx_tick |-> rx_tick);

endmodule
